// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a byte FIFO in front of an 8N1 serialiser (LSB first).
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_fifo #(
  parameter int CLK_PER_BIT     = 1042,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       UART_TX,
  output logic       busy
);

  localparam int DEPTH  = 2 ** FIFO_ADDR_WIDTH;
  localparam int BAUD_W = $clog2(CLK_PER_BIT);
  localparam logic [BAUD_W-1:0]        BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [FIFO_ADDR_WIDTH:0] FULL_CNT  = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Handshake: a byte moves into the FIFO at a posedge where in_valid && in_ready.
  // in_ready depends only on registered state, so in_valid may wait on it.
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   count;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              tx_q;
`ifdef UART_TX_PARITY_EN
  logic              par_q;
`endif

  logic       push;
  logic       pop;
  logic       fifo_empty;
  logic       baud_end;
  logic [7:0] head;

  assign fifo_empty = (count == '0);
  assign in_ready   = (count != FULL_CNT);
  assign push       = in_valid && in_ready;
  assign baud_end   = (baud_cnt == BAUD_LAST);
  assign head       = mem[rd_ptr];
  // Pop from IDLE, or at the end of STOP so the next start bit follows with no gap.
  assign pop        = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && baud_end));
  assign busy       = (state != S_IDLE) || !fifo_empty;
  assign UART_TX    = tx_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      baud_cnt <= ((state == S_IDLE) || baud_end) ? '0 : baud_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (pop) begin
            shreg <= head;
            tx_q  <= 1'b0;
            state <= S_START;
`ifdef UART_TX_PARITY_EN
            par_q <= ^head;
`endif
          end
        end
        S_START: begin
          if (baud_end) begin
            tx_q    <= shreg[0];
            bit_cnt <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q  <= par_q;
              state <= S_PARITY;
`else
              tx_q  <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              shreg   <= shreg >> 1;
              tx_q    <= shreg[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_end) begin
            tx_q  <= 1'b1;
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (baud_end) begin
            if (pop) begin
              shreg <= head;
              tx_q  <= 1'b0;
              state <= S_START;
`ifdef UART_TX_PARITY_EN
              par_q <= ^head;
`endif
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: random and directed bytes, a line decoder that rebuilds frames,
// and a scoreboard of accepted bytes.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int AW  = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       UART_TX;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rst_seen = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_q[$];
  int         mon_t_q[$];
  logic       mon_ok_q[$];
  logic       mon_par_q[$];

  uart_tx_fifo #(.CLK_PER_BIT(CPB), .FIFO_ADDR_WIDTH(AW)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .UART_TX  (UART_TX),
    .busy     (busy)
  );

  // clock / reset bookkeeping
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge RST_N) rst_seen <= rst_seen + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line level for bit slot i of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Line decoder: samples the middle of each bit slot after a falling edge.
  initial begin : line_monitor
    logic [NBITS-1:0] bits;
    int t0;
    int r0;
    forever begin
      @(negedge CLK);
      if (RST_N === 1'b1 && UART_TX === 1'b0) begin
        t0 = cyc;
        r0 = rst_seen;
        for (int s = 0; s < NBITS; s++) begin
          repeat ((s == 0) ? 2 : 4) @(negedge CLK);
          bits[s] = UART_TX;
        end
        if (r0 == rst_seen && RST_N === 1'b1) begin
          mon_q.push_back(bits[8:1]);
          mon_t_q.push_back(t0);
`ifdef UART_TX_PARITY_EN
          mon_ok_q.push_back(bits[0] == 1'b0 && bits[NBITS-1] == 1'b1 && bits[9] == ^bits[8:1]);
          mon_par_q.push_back(bits[9]);
`else
          mon_ok_q.push_back(bits[0] == 1'b0 && bits[NBITS-1] == 1'b1);
          mon_par_q.push_back(1'b0);
`endif
        end
      end
    end
  end

  // driver tasks (entered and left at a negedge)
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      @(negedge CLK);
      n++;
    end
    if (in_ready) exp_q.push_back(b);
    else check("send_timeout", 32'(in_ready), 32'd1);
    @(negedge CLK);
    in_valid = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    wait_idle({tag, "_idle"});
    check({tag, "_count"}, mon_q.size(), exp_q.size());
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(mon_q[i]), 32'(exp_q[i]));
      check($sformatf("%s_frame%0d", tag, i), 32'(mon_ok_q[i]), 32'd1);
    end
    mon_q.delete();
    mon_t_q.delete();
    mon_ok_q.delete();
    mon_par_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int bad;
    int k;
    logic acc;

    // reset state and quiet line
    RST_N    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge CLK);
    check("rst_tx", 32'(UART_TX), 32'd1);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    RST_N = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (UART_TX !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_100_bad_cycles", bad, 0);

    // single 0x55: exact bit timing and return to idle
    in_data  = 8'h55;
    in_valid = 1'b1;
    check("t55_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(8'h55);
    @(negedge CLK);                       // edge N has passed
    in_valid = 1'b0;
    check("t55_pre_start", 32'(UART_TX), 32'd1);
    check("t55_busy_n", 32'(busy), 32'd1);
    @(negedge CLK);                       // after edge N+1
    for (int i = 0; i < NBITS; i++) begin
      check($sformatf("t55_bit%0d", i), 32'(UART_TX), 32'(frame_bit(8'h55, i)));
      if (i < NBITS - 1) repeat (CPB) @(negedge CLK);
    end
    repeat (CPB - 1) @(negedge CLK);      // last cycle of stop
    check("t55_busy_last", 32'(busy), 32'd1);
    @(negedge CLK);                       // after edge N+1+FRAME
    check("t55_busy_end", 32'(busy), 32'd0);
    check("t55_tx_end", 32'(UART_TX), 32'd1);
    compare_stream("t55");

    // five consecutive pushes: fill, full, contiguous frames
    begin
      logic [7:0] burst [5];
      burst[0] = 8'hA3; burst[1] = 8'h00; burst[2] = 8'hFF; burst[3] = 8'h81; burst[4] = 8'h3C;
      for (int i = 0; i < 5; i++) begin
        in_data  = burst[i];
        in_valid = 1'b1;
        acc = in_ready;
        check($sformatf("burst_acc%0d", i), 32'(acc), 32'd1);
        if (acc) exp_q.push_back(burst[i]);
        @(negedge CLK);
      end
      in_valid = 1'b0;
      check("burst_full", 32'(in_ready), 32'd0);
      wait_idle("burst_idle");
      if (mon_t_q.size() >= 5)
        for (int i = 1; i < 5; i++)
          check($sformatf("burst_gap%0d", i), mon_t_q[i] - mon_t_q[i-1], FRAME);
      else
        check("burst_frames", mon_t_q.size(), 5);
      compare_stream("burst");
    end

    // in_valid held high with an incrementing counter
    k = 0;
    bad = 0;
    in_valid = 1'b1;
    while (k < 20 && bad < 2000) begin
      in_data = 8'(k);
      acc = in_ready;
      @(negedge CLK);
      if (acc) begin
        exp_q.push_back(8'(k));
        k++;
      end
      bad++;
    end
    in_valid = 1'b0;
    check("stream_sent", k, 20);
    compare_stream("stream");

    // random bytes with random gaps
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge CLK);
      send_byte(8'($urandom_range(0, 255)));
    end
    compare_stream("rand");

`ifdef UART_TX_PARITY_EN
    send_byte(8'h07);
    wait_idle("par07_idle");
    if (mon_par_q.size() > 0) check("par07_bit", 32'(mon_par_q[0]), 32'd1);
    else check("par07_frames", mon_par_q.size(), 1);
    compare_stream("par07");
    send_byte(8'h03);
    wait_idle("par03_idle");
    if (mon_par_q.size() > 0) check("par03_bit", 32'(mon_par_q[0]), 32'd0);
    else check("par03_frames", mon_par_q.size(), 1);
    compare_stream("par03");
`endif

    // reset in the middle of data bit 3 with two bytes queued
    send_byte(8'h0F);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (16) @(negedge CLK);
    check("abort_pre_busy", 32'(busy), 32'd1);
    RST_N = 1'b0;
    #1;
    check("abort_tx", 32'(UART_TX), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    exp_q.delete();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (UART_TX !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("abort_quiet_bad_cycles", bad, 0);
    check("abort_no_frames", mon_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
